keys_pio_in: RTL
================

// Module: keys_pio_in
// PURPOSE
//  Avalon-MM slave input PIO: the input-direction companion to the LED output PIO.
//  Samples WIDTH asynchronous push-button/switch lines and synchronizes them.
//  Provides a level register, a per-bit edge-capture register and a maskable level IRQ to the Nios II.
//  Sits on the SoC interconnect beside the LED PIO. Game software polls it or takes the interrupt.
// PARAMETERS
//  WIDTH          4      number of input lines (1..32)
//  EDGE_TYPE      0      0=rising, 1=falling, 2=any edge sets edgecapture
//  DEBOUNCE_CYC   50000  stable-cycle count before a debounced level changes (only with KEYS_PIO_DEBOUNCE_EN)
// PORTS
//  clk         in   1      system clock; all logic on posedge
//  reset       in   1      synchronous, active-high reset
//  address     in   2      register select
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe
//  writedata   in   32     write data
//  in_port     in   WIDTH  raw asynchronous inputs
//  readdata    out  32     read data, valid 1 cycle after a select (read latency 1)
//  irq         out  1      level interrupt, active-high
// BEHAVIOUR
//  Register map:
//   - 0: DATA, RO, filtered level [WIDTH-1:0].
//   - 1: reserved, reads 0, writes ignored.
//   - 2: IRQMASK, RW [WIDTH-1:0].
//   - 3: EDGECAP, read; write-1-to-clear per bit.
//  Reset (reset=1 at posedge): sync stages, level, prev level, IRQMASK and EDGECAP all go to 0.
//   readdata=0, irq=0. Reset mid-operation discards pending edges, and the first post-reset level is not
//   treated as an edge: prev level is loaded from level on the first cycle after reset.
//  Sync: 2-flop synchronizer per bit. in_port to DATA level takes 2 cycles (no debounce).
//  Edge detect: compare level vs prev level (1-cycle delay register).
//   - rise = level & ~prev; fall = ~level & prev.
//   - EDGECAP bit sets on the selected edge and stays set (sticky) until cleared.
//  Write: chipselect & ~write_n.
//   - addr 2 loads writedata[WIDTH-1:0].
//   - addr 3 clears bits where writedata=1.
//   - Bits above WIDTH are ignored.
//  Simultaneous edge and clear on the same bit in the same cycle: set wins (bit stays 1).
//  Read: readdata <= chipselect ? mux(address) zero-extended to 32 : 0; registered.
//   Reads have no side effects.
//  irq = |(EDGECAP & IRQMASK), registered (1 cycle after EDGECAP/IRQMASK change).
//   Stays high until software clears the causing bits or masks them.
//  With EDGE_TYPE outside 0..2, the block behaves as 2.
// CONFIGURATION
//  KEYS_PIO_DEBOUNCE_EN defined: per-bit counter of width clog2(DEBOUNCE_CYC+1) after the synchronizer.
//   - Counter resets to 0 whenever the synced input equals the current level, and at reset.
//   - Counter increments while the synced input differs from the level.
//   - On reaching DEBOUNCE_CYC, the level takes the synced value and the counter returns to 0.
//   - A glitch shorter than DEBOUNCE_CYC cycles never changes the level.
//   - Latency in_port to DATA = 2+DEBOUNCE_CYC cycles.
//  Not defined: no counters; level = synchronizer output; DEBOUNCE_CYC unused.
// TESTING
//  1 reset: hold reset 3 cycles with in_port=4'hF -> irq=0, and EDGECAP reads 0 after 5 idle cycles.
//  2 no-debounce rise: EDGE_TYPE=0, IRQMASK=4'h2, in_port 0->4'h2 -> DATA=2 after 2 clk, EDGECAP=2, irq=1 one clk later.
//  3 W1C: write addr3 data 32'h2 -> EDGECAP=0 next cycle, irq=0 one clk after.
//     Repeat with a coincident bit1 edge -> EDGECAP stays 2.
//  4 masking: EDGECAP=4'h5, write IRQMASK=0 -> irq=0. Write IRQMASK=4'h4 -> irq=1; readback addr2=32'h4.
//  5 debounce (macro on, DEBOUNCE_CYC=8): 5-cycle glitch on bit0 -> DATA,EDGECAP unchanged.
//     Hold 20 cycles -> DATA[0]=1 at cycle 10, EDGECAP[0]=1.
//  6 EDGE_TYPE=2: pulse bit3 high then low, clear between -> EDGECAP[3] sets on both edges; addr1 reads 0.

Source files
------------

// File: rtl/keys_pio_if.sv
// Avalon-MM slave bus bundle for the keys input PIO.
// Handshake: a write is accepted on any rising clock edge where chipselect=1 and write_n=0.
// A read is any edge with chipselect=1 and write_n=1. readdata is registered and valid on the
// following edge (fixed read latency 1). There is no waitrequest, so every access completes at once.
interface keys_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/keys_pio_in.sv
// keys_pio_in: Avalon-MM input PIO for push-buttons/switches.
// Two-flop synchronizer, level register, sticky per-bit edge capture (W1C), IRQ mask and a
// registered level interrupt. Define KEYS_PIO_DEBOUNCE_EN to add a per-bit stable-count debouncer
// between the synchronizer and the level; otherwise the level is the synchronizer output.
// Register map: 0 DATA (RO), 1 reserved, 2 IRQMASK (RW), 3 EDGECAP (W1C).
module keys_pio_in #(
  parameter int WIDTH        = 4,
  parameter int EDGE_TYPE    = 0,
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  keys_pio_if.slave        bus
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edge_bits;
  logic [WIDTH-1:0] clr_bits;
  logic [31:0]      rd_mux;
  logic [2:0]       prime_cnt;
  logic             primed;
  logic             wr_en;
  logic             unused_sink;

  // Edge capture stays disabled for the first four cycles after reset: the synchronizer
  // (and debouncer) fill with the live inputs and prev follows level, so a key already
  // held through reset is never reported as an edge.
  assign primed = (prime_cnt == 3'd4);
  assign wr_en  = bus.chipselect & ~bus.write_n;

  // Upper writedata bits are intentionally ignored.
  assign unused_sink = ^{bus.writedata, 32'(DEBOUNCE_CYC)};

  // Two-flop synchronizer, previous-level register and post-reset priming counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      prev      <= '0;
      prime_cnt <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      prev  <= level;
      if (!primed) prime_cnt <= prime_cnt + 3'd1;
    end
  end

`ifdef KEYS_PIO_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYC < 1) ? 1 : $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [CNT_W-1:0] stable_cnt [WIDTH];

  // Per-bit debouncer: level follows the synced input only after DEBOUNCE_CYC differing cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      level <= '0;
      for (int i = 0; i < WIDTH; i++) stable_cnt[i] <= '0;
    end else if (!primed) begin
      level <= sync2;
      for (int i = 0; i < WIDTH; i++) stable_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == level[i]) begin
          stable_cnt[i] <= '0;
        end else if (stable_cnt[i] == CNT_LAST) begin
          level[i]      <= sync2[i];
          stable_cnt[i] <= '0;
        end else begin
          stable_cnt[i] <= stable_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign level = sync2;
`endif

  // Edge selection and software clear mask for this cycle.
  always_comb begin
    edge_bits = '0;
    clr_bits  = '0;
    if (EDGE_TYPE == 0)      edge_bits = level & ~prev;
    else if (EDGE_TYPE == 1) edge_bits = ~level & prev;
    else                     edge_bits = (level & ~prev) | (~level & prev);
    if (wr_en && bus.address == 2'd3) clr_bits = bus.writedata[WIDTH-1:0];
  end

  // Sticky edge capture; a new edge wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) edgecap <= '0;
    else       edgecap <= (edgecap & ~clr_bits) | (primed ? edge_bits : '0);
  end

  // Interrupt mask register.
  always_ff @(posedge clk) begin
    if (reset) irqmask <= '0;
    else if (wr_en && bus.address == 2'd2) irqmask <= bus.writedata[WIDTH-1:0];
  end

  // Read mux, zero-extended to the bus width.
  always_comb begin
    rd_mux = '0;
    case (bus.address)
      2'd0:    rd_mux = 32'(level);
      2'd2:    rd_mux = 32'(irqmask);
      2'd3:    rd_mux = 32'(edgecap);
      default: rd_mux = '0;
    endcase
  end

  // Registered read data and level interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.readdata <= '0;
      bus.irq      <= 1'b0;
    end else begin
      bus.readdata <= bus.chipselect ? rd_mux : 32'd0;
      bus.irq      <= |(edgecap & irqmask);
    end
  end

endmodule
